// File: rtl/foo_array_deserializer_if.sv
// Element-stream / packed-word bundle shared by the foo array deserializer and its neighbours.
// The slave modport is the deserializer's view; the master modport is the stream source/word sink.
interface foo_array_deserializer_if #(
    parameter int N_ELEM = 4,
    parameter int ELEM_W = 1,
    parameter int CNT_W  = $clog2(N_ELEM + 1)
);
    logic                     in_valid;
    logic                     in_ready;
    logic [ELEM_W-1:0]        in_elem;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [N_ELEM*ELEM_W-1:0] out_data;
    logic [CNT_W-1:0]         out_count;
    logic                     out_short;

    modport master (
        output in_valid, in_elem, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_short
    );

    modport slave (
        input  in_valid, in_elem, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_short
    );
endinterface

// File: rtl/foo_array_deserializer.sv
// Collects a serial stream of foo elements into one packed word (element k at [k*ELEM_W +: ELEM_W]).
// Words close after N_ELEM elements or early on in_last; one element per cycle across word boundaries.
module foo_array_deserializer #(
    parameter int N_ELEM = 4,
    parameter int ELEM_W = 1,
    parameter int CNT_W  = $clog2(N_ELEM + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    foo_array_deserializer_if.slave  bus
);
    localparam int DW = N_ELEM * ELEM_W;

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_idx;
    logic [DW-1:0]    r_buf;
    logic             r_out_valid;
    logic [DW-1:0]    r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_short;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_consume;
    logic          w_last_slot;
    logic [DW-1:0] w_buf_wr;
    logic [DW-1:0] w_first_word;

    // HOLD can take a new element only in the cycle the held word leaves.
    assign w_in_ready  = !rst && ((r_state == S_FILL) || bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_consume   = r_out_valid && bus.out_ready;
    assign w_last_slot = (r_idx == CNT_W'(N_ELEM - 1));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_buf_wr = r_buf;
        for (int k = 0; k < N_ELEM; k++) begin
            if (r_idx == CNT_W'(k)) begin
                w_buf_wr[k*ELEM_W +: ELEM_W] = bus.in_elem;
            end
        end
    end

    always_comb begin
        w_first_word           = '0;
        w_first_word[ELEM_W-1:0] = bus.in_elem;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_idx       <= '0;
            r_buf       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_short <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_buf <= w_buf_wr;
                        r_idx <= r_idx + CNT_W'(1);
                        if (w_last_slot || bus.in_last) begin
                            r_state     <= S_HOLD;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_buf_wr;
                            r_out_count <= r_idx + CNT_W'(1);
                            r_out_short <= bus.in_last && !w_last_slot;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_consume) begin
                        if (w_accept) begin
                            // First element of the next word lands in slot 0; older slots are wiped.
                            r_buf <= w_first_word;
                            r_idx <= CNT_W'(1);
                            if (bus.in_last) begin
                                r_out_data  <= w_first_word;
                                r_out_count <= CNT_W'(1);
                                r_out_short <= 1'b1;
                            end else begin
                                r_state     <= S_FILL;
                                r_out_valid <= 1'b0;
                            end
                        end else begin
                            r_state     <= S_FILL;
                            r_idx       <= '0;
                            r_buf       <= '0;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;
    assign bus.out_short = r_out_short;
endmodule

// File: tb/tb_foo_array_deserializer.sv
// Scoreboard bench for foo_array_deserializer: a queue-based frame model predicts words,
// a negedge monitor pops and compares every word the DUT hands over.
module tb_foo_array_deserializer;
    localparam int N_ELEM = 4;
    localparam int ELEM_W = 1;
    localparam int CNT_W  = $clog2(N_ELEM + 1);
    localparam int DW     = N_ELEM * ELEM_W;

    typedef struct {
        logic [DW-1:0]    data;
        logic [CNT_W-1:0] count;
        logic             shrt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    foo_array_deserializer_if #(.N_ELEM(N_ELEM), .ELEM_W(ELEM_W), .CNT_W(CNT_W)) bus_if ();

    foo_array_deserializer #(.N_ELEM(N_ELEM), .ELEM_W(ELEM_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   words_pushed = 0;
    int   words_popped = 0;
    bit   rdy_rand = 1'b0;
    exp_t exp_q[$];
    logic [ELEM_W-1:0] cur_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    endtask

    // Frame model: elements pile up until N_ELEM are held or one carries in_last.
    task automatic model_push(input logic [ELEM_W-1:0] e, input logic l);
        exp_t w;
        cur_q.push_back(e);
        if (cur_q.size() == N_ELEM || l) begin
            w.data = '0;
            foreach (cur_q[k]) w.data = w.data | (DW'(cur_q[k]) << (k * ELEM_W));
            w.count = CNT_W'(cur_q.size());
            w.shrt  = l && (cur_q.size() < N_ELEM);
            exp_q.push_back(w);
            words_pushed++;
            cur_q.delete();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the element was accepted.
    task automatic send(input logic [ELEM_W-1:0] e, input logic l);
        int guard = 0;
        bit ok = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.in_elem  = e;
        bus_if.in_last  = l;
        while (guard < 200) begin
            @(negedge clk);
            if (bus_if.in_ready) begin
                ok = 1'b1;
                break;
            end
            guard++;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
        end
        @(posedge clk);
        #1;
        if (ok) model_push(e, l);
        bus_if.in_valid = 1'b0;
        bus_if.in_last  = 1'b0;
    endtask

    initial begin : monitor
        exp_t w;
        forever begin
            @(negedge clk);
            if (!rst && bus_if.out_valid && bus_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got data %0h count %0d, none expected",
                             bus_if.out_data, bus_if.out_count);
                end else begin
                    w = exp_q.pop_front();
                    words_popped++;
                    check("sb_data",  64'(bus_if.out_data),  64'(w.data));
                    check("sb_count", 64'(bus_if.out_count), 64'(w.count));
                    check("sb_short", 64'(bus_if.out_short), 64'(w.shrt));
                end
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) bus_if.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_elem   = '0;
        bus_if.in_last   = 1'b0;
        bus_if.out_ready = 1'b0;

        #1;
        check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        check("rst_out_data",  64'(bus_if.out_data),  64'd0);
        check("rst_out_count", 64'(bus_if.out_count), 64'd0);
        check("rst_out_short", 64'(bus_if.out_short), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus_if.in_ready), 64'd1);

        // Full word 1,0,1,1 with a one-cycle latency.
        bus_if.out_ready = 1'b1;
        send(1, 0); send(0, 0); send(1, 0);
        check("t1_no_early_valid", 64'(bus_if.out_valid), 64'd0);
        send(1, 0);
        check("t1_valid", 64'(bus_if.out_valid), 64'd1);
        check("t1_data",  64'(bus_if.out_data),  64'b1101);
        check("t1_count", 64'(bus_if.out_count), 64'd4);
        check("t1_short", 64'(bus_if.out_short), 64'd0);

        // Short frame 1,1 closed by in_last.
        send(1, 0); send(1, 1);
        check("t2_data",  64'(bus_if.out_data),  64'b0011);
        check("t2_count", 64'(bus_if.out_count), 64'd2);
        check("t2_short", 64'(bus_if.out_short), 64'd1);
        @(posedge clk);
        #1;

        // Backpressure: held word stays stable, incoming element is refused.
        bus_if.out_ready = 1'b0;
        send(1, 0); send(0, 0); send(0, 0); send(1, 0);
        bus_if.in_valid = 1'b1;
        bus_if.in_elem  = 1;
        bus_if.in_last  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t3_in_ready_low", 64'(bus_if.in_ready),  64'd0);
            check("t3_hold_valid",   64'(bus_if.out_valid), 64'd1);
            check("t3_hold_data",    64'(bus_if.out_data),  64'b1001);
        end
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b1;
        #1;
        check("t3_in_ready_same_cycle", 64'(bus_if.in_ready), 64'd1);
        send(1, 0); send(0, 0); send(0, 0); send(1, 1);

        // Twelve elements back-to-back must take exactly twelve cycles.
        t0 = cyc;
        for (int i = 0; i < 12; i++) send(ELEM_W'($urandom), 0);
        check("t4_no_stall_cycles", 64'(cyc - t0), 64'd12);

        // Reset mid-frame discards the partial word.
        send(1, 0); send(1, 0);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 64'(bus_if.out_valid), 64'd0);
        check("t5_rst_data",  64'(bus_if.out_data),  64'd0);
        check("t5_rst_queue", 64'(exp_q.size()),     64'd0);
        cur_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 0); send(0, 0); send(0, 0); send(1, 0);
        check("t5_data",  64'(bus_if.out_data),  64'b1000);
        check("t5_count", 64'(bus_if.out_count), 64'd4);

        // Random traffic with random gaps, in_last and output backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send(ELEM_W'($urandom), ($urandom_range(0, 4) == 0));
        end
        send(ELEM_W'($urandom), 1);
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b1;
        for (int g = 0; g < 50 && exp_q.size() != 0; g++) @(negedge clk);
        @(negedge clk);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("words_popped", 64'(words_popped), 64'(words_pushed));
        check("idle_after_drain", 64'(bus_if.out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
